// File: rtl/alu_writeback_pkg.sv
// Shared constants for the ALU writeback stage: condition codes, NZCV bit
// positions and default datapath sizes.
package alu_writeback_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/alu_writeback_cond_check.sv
// Combinational condition-code evaluator: (cond, NZCV) -> pass.
// Shared with the branch unit, so it carries no state.
module alu_writeback_cond_check
  import alu_writeback_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: one-deep result register with valid/ready, condition
// check against NZCV, commit to the register file and flags, operand read ports.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int NREGS  = 16,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic [3:0]    in_new_flag,
  input  logic [3:0]    in_cond,
  input  logic          in_s,
  input  logic          in_wr_en,
  input  logic [AW-1:0] in_rd,
  input  logic          hold,
  input  logic          flush,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b,
  output logic [3:0]    flags,
  output logic          commit_valid,
  output logic          commit_pass,
  output logic [AW-1:0] commit_rd,
  output logic [DW-1:0] commit_data,
  output logic [15:0]   retired
);

  logic          vld_p0;
  logic [DW-1:0] result_p0;
  logic [3:0]    new_flag_p0;
  logic [3:0]    cond_p0;
  logic          s_p0;
  logic          wr_en_p0;
  logic [AW-1:0] rd_p0;

  logic [DW-1:0] regs [NREGS];

  logic accept;
  logic commit;
  logic pass;
  logic wr_fire;

  assign in_ready = !flush && (!vld_p0 || !hold);
  assign accept   = in_valid && in_ready;
  assign commit   = vld_p0 && !hold && !flush;
  assign wr_fire  = commit && pass && wr_en_p0;

  alu_writeback_cond_check u_cond_check (
    .cond  (cond_p0),
    .flags (flags),
    .pass  (pass)
  );

  // Stage p0: capture the ALU beat; flush beats both accept and commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0      <= 1'b0;
      result_p0   <= '0;
      new_flag_p0 <= '0;
      cond_p0     <= '0;
      s_p0        <= 1'b0;
      wr_en_p0    <= 1'b0;
      rd_p0       <= '0;
    end else begin
      if (flush)       vld_p0 <= 1'b0;
      else if (accept) vld_p0 <= 1'b1;
      else if (commit) vld_p0 <= 1'b0;
      if (accept) begin
        result_p0   <= in_result;
        new_flag_p0 <= in_new_flag;
        cond_p0     <= in_cond;
        s_p0        <= in_s;
        wr_en_p0    <= in_wr_en;
        rd_p0       <= in_rd;
      end
    end
  end

  // Commit stage: architectural state plus the registered commit report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flags        <= 4'b0000;
      commit_valid <= 1'b0;
      commit_pass  <= 1'b0;
      commit_rd    <= '0;
      commit_data  <= '0;
      retired      <= 16'd0;
    end else begin
      commit_valid <= commit;
      if (commit) begin
        commit_pass <= pass;
        commit_rd   <= rd_p0;
        commit_data <= result_p0;
        retired     <= retired + 16'd1;
        if (wr_fire)     regs[rd_p0] <= result_p0;
        if (pass && s_p0) flags      <= new_flag_p0;
      end
    end
  end

  // Same-cycle forwarding lets operand fetch see a write landing at this edge.
  assign rd_data_a = (BYPASS != 0 && wr_fire && rd_p0 == rd_addr_a) ? result_p0 : regs[rd_addr_a];
  assign rd_data_b = (BYPASS != 0 && wr_fire && rd_p0 == rd_addr_b) ? result_p0 : regs[rd_addr_b];

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed beats with literal expectations plus a
// behavioural model of the architectural state checked every cycle.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_new_flag;
  logic [3:0]  in_cond;
  logic        in_s;
  logic        in_wr_en;
  logic [3:0]  in_rd;
  logic        hold;
  logic        flush;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [3:0]  flags;
  logic        commit_valid;
  logic        commit_pass;
  logic [3:0]  commit_rd;
  logic [31:0] commit_data;
  logic [15:0] retired;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_writeback #(.NREGS(16), .AW(4), .DW(32), .BYPASS(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_new_flag  (in_new_flag),
    .in_cond      (in_cond),
    .in_s         (in_s),
    .in_wr_en     (in_wr_en),
    .in_rd        (in_rd),
    .hold         (hold),
    .flush        (flush),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .flags        (flags),
    .commit_valid (commit_valid),
    .commit_pass  (commit_pass),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .retired      (retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of each condition code, from named NZCV bits.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] result;
    logic [3:0]  nf;
    logic [3:0]  cond;
    logic        s;
    logic        wr_en;
    logic [3:0]  rd;
  } beat_t;

  // Model state: at most one pending beat, architectural registers and flags.
  bit          m_have;
  beat_t       m_beat;
  logic [31:0] m_regs [16];
  logic [3:0]  m_flags;
  logic [15:0] m_ret;
  logic        m_cv;
  logic        m_cp;
  logic [3:0]  m_crd;
  logic [31:0] m_cdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have  <= 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] <= 32'd0;
      m_flags <= 4'd0;
      m_ret   <= 16'd0;
      m_cv    <= 1'b0;
      m_cp    <= 1'b0;
      m_crd   <= 4'd0;
      m_cdata <= 32'd0;
    end else begin : model_step
      bit rdy, com, ps;
      rdy = !flush && (!m_have || !hold);
      com = m_have && !hold && !flush;
      ps  = cond_ok(m_beat.cond, m_flags);
      m_cv <= com;
      if (com) begin
        m_cp    <= ps;
        m_crd   <= m_beat.rd;
        m_cdata <= m_beat.result;
        m_ret   <= m_ret + 16'd1;
        if (ps && m_beat.wr_en) m_regs[m_beat.rd] <= m_beat.result;
        if (ps && m_beat.s)     m_flags <= m_beat.nf;
      end
      if (flush) m_have <= 1'b0;
      else if (in_valid && rdy) begin
        m_have <= 1'b1;
        m_beat <= '{in_result, in_new_flag, in_cond, in_s, in_wr_en, in_rd};
      end else if (com) m_have <= 1'b0;
    end
  end

  function automatic logic [31:0] exp_read(input logic [3:0] addr);
    if (m_have && !hold && !flush && cond_ok(m_beat.cond, m_flags) &&
        m_beat.wr_en && m_beat.rd == addr)
      return m_beat.result;
    return m_regs[addr];
  endfunction

  // Compare process, on the falling edge while out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("mon_in_ready", 32'(in_ready), 32'(!flush && (!m_have || !hold)));
      chk("mon_flags", 32'(flags), 32'(m_flags));
      chk("mon_retired", 32'(retired), 32'(m_ret));
      chk("mon_commit_valid", 32'(commit_valid), 32'(m_cv));
      if (m_cv) begin
        chk("mon_commit_pass", 32'(commit_pass), 32'(m_cp));
        chk("mon_commit_rd", 32'(commit_rd), 32'(m_crd));
        chk("mon_commit_data", commit_data, m_cdata);
      end
      chk("mon_rd_data_a", rd_data_a, exp_read(rd_addr_a));
      chk("mon_rd_data_b", rd_data_b, exp_read(rd_addr_b));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] r, input logic [3:0] rd, input logic [3:0] c,
                          input logic s, input logic [3:0] nf, input logic we);
    in_valid = 1'b1; in_result = r; in_rd = rd; in_cond = c;
    in_s = s; in_new_flag = nf; in_wr_en = we;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_new_flag = '0; in_cond = '0;
    in_s = 1'b0; in_wr_en = 1'b0; in_rd = '0; hold = 1'b0; flush = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < 16; i++) begin
      step();
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      #1;
      chk("rst_rd_a", rd_data_a, 32'd0);
      chk("rst_rd_b", rd_data_b, 32'd0);
    end
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);

    // Unconditional write with flag update
    step(); set_beat(32'h5, 4'd3, 4'hE, 1'b1, 4'b0100, 1'b1);
    step(); in_valid = 1'b0;
    step(); rd_addr_a = 4'd3; #1;
    chk("al_rd3", rd_data_a, 32'h5);
    chk("al_flags", 32'(flags), 32'h4);
    chk("al_pass", 32'(commit_pass), 32'd1);
    chk("al_cv", 32'(commit_valid), 32'd1);
    chk("al_retired", 32'(retired), 32'd1);

    // NE with Z set fails: no write, no flag change, still retires
    set_beat(32'h7, 4'd4, 4'h1, 1'b1, 4'b0000, 1'b1);
    step(); in_valid = 1'b0;
    step(); rd_addr_a = 4'd4; #1;
    chk("ne_pass", 32'(commit_pass), 32'd0);
    chk("ne_cv", 32'(commit_valid), 32'd1);
    chk("ne_rd4", rd_data_a, 32'd0);
    chk("ne_flags", 32'(flags), 32'h4);
    chk("ne_retired", 32'(retired), 32'd2);

    // Back-to-back beats to r2
    set_beat(32'h1, 4'd2, 4'hE, 1'b0, 4'b0000, 1'b1); #1;
    chk("b2b_ready1", 32'(in_ready), 32'd1);
    step(); in_result = 32'h2; #1;
    chk("b2b_ready2", 32'(in_ready), 32'd1);
    step(); in_result = 32'h3; #1;
    chk("b2b_ready3", 32'(in_ready), 32'd1);
    chk("b2b_cv1", 32'(commit_valid), 32'd1);
    chk("b2b_data1", commit_data, 32'h1);
    step(); in_valid = 1'b0; rd_addr_a = 4'd2; #1;
    chk("b2b_cv2", 32'(commit_valid), 32'd1);
    chk("b2b_data2", commit_data, 32'h2);
    chk("b2b_bypass", rd_data_a, 32'h3);
    step(); #1;
    chk("b2b_cv3", 32'(commit_valid), 32'd1);
    chk("b2b_data3", commit_data, 32'h3);
    chk("b2b_rd2", rd_data_a, 32'h3);
    chk("b2b_retired", 32'(retired), 32'd5);

    // Hold with pipe full, then flush
    set_beat(32'h9, 4'd2, 4'hE, 1'b0, 4'b0000, 1'b1);
    step(); hold = 1'b1; set_beat(32'hAA, 4'd5, 4'hE, 1'b0, 4'b0000, 1'b1); #1;
    chk("hold_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_cv", 32'(commit_valid), 32'd0);
      chk("hold_ready_n", 32'(in_ready), 32'd0);
    end
    flush = 1'b1; #1;
    chk("flush_ready", 32'(in_ready), 32'd0);
    step(); flush = 1'b0; hold = 1'b0; in_valid = 1'b0; #1;
    chk("flush_cv", 32'(commit_valid), 32'd0);
    step(); rd_addr_a = 4'd2; rd_addr_b = 4'd5; #1;
    chk("flush_cv2", 32'(commit_valid), 32'd0);
    chk("flush_rd2", rd_data_a, 32'h3);
    chk("flush_rd5", rd_data_b, 32'h0);
    chk("flush_retired", 32'(retired), 32'd5);

    // Hold with pipe empty still accepts one beat
    hold = 1'b1; set_beat(32'h55, 4'd6, 4'hE, 1'b0, 4'b0000, 1'b1); #1;
    chk("hempty_ready", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0; #1;
    chk("hfull_ready", 32'(in_ready), 32'd0);
    step(); #1;
    chk("hfull_cv", 32'(commit_valid), 32'd0);
    hold = 1'b0;
    step(); rd_addr_a = 4'd6; #1;
    chk("hrel_cv", 32'(commit_valid), 32'd1);
    chk("hrel_data", commit_data, 32'h55);
    chk("hrel_rd6", rd_data_a, 32'h55);
    chk("hrel_retired", 32'(retired), 32'd6);

    // Sweep every condition code against evolving flags
    for (int i = 0; i < 48; i++) begin
      set_beat(32'h1000_0000 + 32'(i), 4'(i % 16), 4'(i % 16), 1'b1,
               4'((i * 7 + 3) % 16), (i % 3) != 0);
      rd_addr_a = 4'(i % 16); rd_addr_b = 4'((i + 1) % 16);
      step();
    end
    in_valid = 1'b0;
    step(); step();

    // Retired counter wrap
    n = 32'h0000FFFF - 32'(m_ret);
    set_beat(32'h0, 4'd0, 4'hF, 1'b0, 4'b0000, 1'b0);
    repeat (n) step();
    in_valid = 1'b0;
    step(); #1;
    chk("wrap_ffff", 32'(retired), 32'h0000FFFF);
    set_beat(32'h0, 4'd0, 4'hF, 1'b0, 4'b0000, 1'b0);
    step(); in_valid = 1'b0;
    step(); #1;
    chk("wrap_zero", 32'(retired), 32'd0);
    chk("wrap_nv_pass", 32'(commit_pass), 32'd0);

    // Asynchronous reset with a beat pending
    set_beat(32'hDEAD, 4'd7, 4'hE, 1'b1, 4'b1010, 1'b1);
    step(); set_beat(32'h77, 4'd7, 4'hE, 1'b1, 4'b0001, 1'b1);
    step(); in_valid = 1'b0; rd_addr_a = 4'd7; rd_addr_b = 4'd7; #1;
    chk("pre_flags", 32'(flags), 32'hA);
    chk("pre_bypass_a", rd_data_a, 32'h77);
    chk("pre_bypass_b", rd_data_b, 32'h77);
    chk("pre_retired", 32'(retired), 32'd1);
    chk("pre_cv", 32'(commit_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_flags", 32'(flags), 32'd0);
    chk("arst_retired", 32'(retired), 32'd0);
    chk("arst_cv", 32'(commit_valid), 32'd0);
    chk("arst_cdata", commit_data, 32'd0);
    chk("arst_rd7", rd_data_a, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step(); step(); #1;
    chk("post_cv", 32'(commit_valid), 32'd0);
    chk("post_retired", 32'(retired), 32'd0);
    chk("post_rd7", rd_data_a, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Stage directly downstream of the master ALU. Registers each ALU result with a valid/ready handshake, then evaluates the instruction condition code against the architectural NZCV flag register.
- On a passing condition, commits Result to a 16x32 register file and, when S is set, commits New_Flag.
- Drives the read ports and current flags back to the operand-fetch side, so it also sources the ALU's Reg1/Reg2/Flag inputs.

Parameters:
- NREGS, 16, number of architectural registers (power of two).
- AW, 4, register index width, log2(NREGS).
- DW, 32, datapath width.
- BYPASS, 1, 1 = read ports return same-cycle commit data on index match.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result beat valid.
- in_ready  out  1  stage can accept a beat.
- in_result  in  DW  ALU Result.
- in_new_flag  in  4  ALU New_Flag {N,Z,C,V}.
- in_cond  in  4  condition code of the instruction.
- in_s  in  1  flag-update request.
- in_wr_en  in  1  instruction writes a destination register (0 for SET_FLAG-type ops).
- in_rd  in  AW  destination register index.
- hold  in  1  external stall; blocks commit.
- flush  in  1  discard the pending beat.
- rd_addr_a, rd_addr_b  in  AW each  operand read indices.
- rd_data_a, rd_data_b  out  DW each  operand read data (combinational).
- flags  out  4  architectural NZCV; feeds the ALU Flag input.
- commit_valid  out  1  one-cycle pulse per committed beat.
- commit_pass  out  1  condition result of the committed beat.
- commit_rd  out  AW  index of the committed beat.
- commit_data  out  DW  data of the committed beat.
- retired  out  16  count of committed beats.

Behaviour:
- Reset (async, rst_n=0):
  - pipe_valid=0; all registers=0; flags=4'b0000; retired=0.
  - commit_valid=0, commit_pass=0, commit_rd=0, commit_data=0.
  - Asserting reset mid-operation drops the pending beat with no partial commit.
- Single pipeline register, states EMPTY and FULL:
  - in_ready = !flush && (!pipe_valid || !hold).
  - A beat is accepted when in_valid && in_ready, and captured at the clock edge.
- Commit fires when pipe_valid && !hold && !flush. Latency is accept at edge N, commit effects visible after edge N+1.
- Back-to-back operation: a commit and an accept in the same cycle gives 1 beat/cycle throughput, and the pipe stays FULL.
- Condition evaluation uses the flags register value at commit time, which already includes all earlier commits:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C.
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z.
  - A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F NV 0.
- On commit with pass=1:
  - If wr_en, regfile[rd] <= result.
  - If s, flags <= new_flag.
- On commit with pass=0: no register or flag change, but commit_valid still pulses and retired still increments.
- commit_* outputs are registered and reflect the beat committed on the previous edge; commit_valid lasts one cycle.
- retired wraps from 16'hFFFF to 0.
- Read ports:
  - Combinational from the array.
  - If BYPASS=1 and a commit with pass && wr_en targets the same index in the same cycle, return the committing data.
  - Both ports may read the same index.
- Flush:
  - Clears pipe_valid at the next edge; nothing is committed.
  - Flush beats hold: flush has priority over hold.
  - in_ready=0 while flush is high, so no beat is accepted in a flush cycle.
- Hold with pipe FULL: no commit, in_ready=0, pipe contents stable.
- Hold with pipe EMPTY: one beat may still be accepted.

Decomposition:
- Shared package:
  - Condition-code constants COND_EQ..COND_NV.
  - Flag bit positions FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - DW/AW defaults.
- One natural sub-module: cond_check, a combinational function (cond, flags) -> pass. It is reused by the branch logic later.
- The register file stays inline.

Test Plan:
- Reset then read all indices -> rd_data_a/b=0, flags=0000, retired=0, commit_valid=0.
- Beat result=32'h0000_0005, rd=3, cond=E, s=1, new_flag=0100, wr_en=1 -> two edges later rd_data_a(3)=5, flags=0100, commit_pass=1, retired=1.
- Flags=0100, then beat cond=1 (NE), rd=4, result=7 -> commit_pass=0, reg4 stays 0, flags unchanged, retired increments.
- Back-to-back beats to rd=2: 1, then 2, then 3, cond=E, in_valid held high -> in_ready=1 throughout, three consecutive commit_valid pulses, reg2=3. With BYPASS=1, a read of index 2 during the final commit cycle returns 3.
- Hold=1 for 3 cycles with pipe FULL, then flush=1 -> in_ready=0, no commit pulse, beat discarded, register unchanged.
- Preload retired to 16'hFFFF, or run 65536 commits, then one more commit -> retired=0. Assert rst_n=0 asynchronously mid-beat -> outputs zero immediately with no clock edge.
